// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the data-side SRAM controller
package sram_ctrl_pkg;

  localparam int   REG_BUS_W    = 32;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    SRAM_IDLE  = 2'd0,
    SRAM_READ  = 2'd1,
    SRAM_WRITE = 2'd2,
    SRAM_DONE  = 2'd3
  } sram_state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - CPU RAM-port bus between the core and the SRAM controller
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic                 ce;
  logic                 we;
  logic [REG_BUS_W-1:0] addr;
  logic [3:0]           sel;
  logic [REG_BUS_W-1:0] wdata;
  logic [REG_BUS_W-1:0] rdata;
  logic                 stallreq;

  modport master (output ce, we, addr, sel, wdata, input rdata, stallreq);
  modport slave  (input ce, we, addr, sel, wdata, output rdata, stallreq);

endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-cycle CPU load/store to multi-cycle async SRAM access
// with programmable wait states; stalls the pipeline until the access reaches DONE.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_ctrl_if.slave           bus,
  output logic [ADDR_W-1:0]    sram_addr_o,
  input  logic [REG_BUS_W-1:0] sram_dq_i,
  output logic [REG_BUS_W-1:0] sram_dq_o,
  output logic                 sram_dq_oe_o,
  output logic                 sram_ce_n_o,
  output logic                 sram_oe_n_o,
  output logic                 sram_we_n_o,
  output logic [3:0]           sram_be_n_o
);

  localparam int CNT_W = $clog2(imax(RD_WAIT, WR_WAIT)) + 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);

  sram_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept, rd_sample;
  logic                 we_q;
  logic [3:0]           sel_q, sel_eff;
  logic                 we_eff, active_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [REG_BUS_W-1:0] wdata_q, data_o_q;
  logic                 ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic                 ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic [3:0]           be_n_q, be_n_d;

  logic unused_addr;
  assign unused_addr = ^{bus.addr[REG_BUS_W-1:ADDR_W+2], bus.addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SRAM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    rd_sample = 1'b0;
    case (state_q)
      SRAM_IDLE: begin
        if (bus.ce == CHIP_ENABLE) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = (bus.we == WRITE_ENABLE) ? SRAM_WRITE : SRAM_READ;
        end
      end
      SRAM_READ: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RD_LAST) begin
          rd_sample = 1'b1;
          state_d   = SRAM_DONE;
        end
      end
      SRAM_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == WR_LAST) state_d = SRAM_DONE;
      end
      SRAM_DONE: state_d = SRAM_IDLE;
      default:   state_d = SRAM_IDLE;
    endcase

    // Pad strobes are registered from the next state so they line up with the FSM state.
    sel_eff  = accept ? bus.sel : sel_q;
    we_eff   = accept ? bus.we  : we_q;
    active_d = (state_d == SRAM_READ) || (state_d == SRAM_WRITE);
    ce_n_d   = !active_d;
    oe_n_d   = (state_d != SRAM_READ);
    we_n_d   = (state_d != SRAM_WRITE);
    be_n_d   = active_d ? ~sel_eff : 4'hF;
    dq_oe_d  = (state_d == SRAM_WRITE) || ((state_d == SRAM_DONE) && we_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= 4'hF;
      dq_oe_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      data_o_q <= '0;
    end else begin
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      dq_oe_q <= dq_oe_d;
      if (accept) begin
        addr_q  <= bus.addr[ADDR_W+1:2];
        wdata_q <= bus.wdata;
        sel_q   <= bus.sel;
        we_q    <= bus.we;
      end
      if (rd_sample) data_o_q <= sram_dq_i;
    end
  end

  // A flushed request (ce dropped) releases the pipeline at once; the SRAM cycle still finishes.
  assign bus.stallreq = rst_n & bus.ce & (state_q != SRAM_DONE);
  assign bus.rdata    = data_o_q;

  assign sram_addr_o  = addr_q;
  assign sram_dq_o    = wdata_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_be_n_o  = be_n_q;

endmodule
